// File: rtl/time_counter_if.sv
// Time-of-day counter bus: run/adjust controls in,
// BCD time and day-carry pulse out.
interface time_counter_if;
   logic        run;
   logic [2:0]  cnt_inc;
   logic [2:0]  cnt_dec;
   logic        full_flag;
   logic [23:0] Data;

   modport master (
      output run,
      output cnt_inc,
      output cnt_dec,
      input  full_flag,
      input  Data
   );

   modport slave (
      input  run,
      input  cnt_inc,
      input  cnt_dec,
      output full_flag,
      output Data
   );
endinterface

// File: rtl/time_counter.sv
// BCD hh:mm:ss time-of-day counter with a one-second
// prescaler, per-field adjust and a day-carry pulse.
// Ports: Clk, Reset (async, active high),
//   bus.run        time advances when 1
//   bus.cnt_inc    edge-detected +1 (b0 s, b1 m, b2 h)
//   bus.cnt_dec    edge-detected -1, same mapping
//   bus.full_flag  one-cycle 23:59:59 -> 00:00:00 pulse
//   bus.Data       {hh, mm, ss} BCD, registered
module time_counter #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic          Clk,
   input  logic          Reset,
   time_counter_if.slave bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
   localparam logic [23:0] DAY_END = 24'h235959;
   localparam logic [7:0] SM_TOP = 8'h59;
   localparam logic [7:0] H_TOP = 8'h23;

   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;

   logic [2:0] inc_q;
   logic [2:0] dec_q;
   logic [2:0] inc_e;
   logic [2:0] dec_e;
   logic [2:0] up;
   logic [2:0] dn;

   logic adj;
   logic sec_adj;
   logic tick;

   logic [7:0] hh_q;
   logic [7:0] mm_q;
   logic [7:0] ss_q;
   logic [7:0] hh_d;
   logic [7:0] mm_d;
   logic [7:0] ss_d;

   logic full_q;
   logic full_d;

   function automatic logic [7:0] bcd_up(
      input logic [7:0] v,
      input logic [7:0] top
   );
      logic [7:0] r;
      if (v == top)
         r = 8'h00;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic [7:0] bcd_dn(
      input logic [7:0] v,
      input logic [7:0] top
   );
      logic [7:0] r;
      if (v == 8'h00)
         r = top;
      else if (v[3:0] == 4'd0)
         r = {v[7:4] - 4'd1, 4'd9};
      else
         r = {v[7:4], v[3:0] - 4'd1};
      return r;
   endfunction

   // Adjusts wrap inside one field; carries never
   // propagate to the neighbouring field.
   function automatic logic [7:0] fld_adj(
      input logic [7:0] v,
      input logic       u,
      input logic       d,
      input logic [7:0] top
   );
      logic [7:0] r;
      r = v;
      unique case (1'b1)
         u:       r = bcd_up(v, top);
         d:       r = bcd_dn(v, top);
         default: r = v;
      endcase
      return r;
   endfunction

   // Edge detect; inc and dec on the same field cancel.
   always_comb begin
      inc_e   = bus.cnt_inc & ~inc_q;
      dec_e   = bus.cnt_dec & ~dec_q;
      up      = inc_e & ~dec_e;
      dn      = dec_e & ~inc_e;
      adj     = |(inc_e | dec_e);
      sec_adj = inc_e[0] | dec_e[0];
      tick    = bus.run && (pre_q == LAST);
   end

   // A seconds adjust restarts the second so the next
   // tick comes a full period later.
   always_comb begin
      pre_d = pre_q;
      if (sec_adj)
         pre_d = '0;
      else if (bus.run)
         pre_d = tick ? '0 : pre_q + PW'(1);
   end

   // Any adjust event swallows a coincident tick.
   always_comb begin
      hh_d   = hh_q;
      mm_d   = mm_q;
      ss_d   = ss_q;
      full_d = 1'b0;
      if (adj) begin
         ss_d = fld_adj(ss_q, up[0], dn[0], SM_TOP);
         mm_d = fld_adj(mm_q, up[1], dn[1], SM_TOP);
         hh_d = fld_adj(hh_q, up[2], dn[2], H_TOP);
      end else if (tick) begin
         ss_d = bcd_up(ss_q, SM_TOP);
         if (ss_q == SM_TOP) begin
            mm_d = bcd_up(mm_q, SM_TOP);
            if (mm_q == SM_TOP)
               hh_d = bcd_up(hh_q, H_TOP);
         end
         full_d = ({hh_q, mm_q, ss_q} == DAY_END);
      end
   end

   // Edge history resets to all-ones so a request held
   // across reset release is not seen as a new edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pre_q  <= '0;
         inc_q  <= 3'b111;
         dec_q  <= 3'b111;
         hh_q   <= 8'h00;
         mm_q   <= 8'h00;
         ss_q   <= 8'h00;
         full_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         inc_q  <= bus.cnt_inc;
         dec_q  <= bus.cnt_dec;
         hh_q   <= hh_d;
         mm_q   <= mm_d;
         ss_q   <= ss_d;
         full_q <= full_d;
      end
   end

   assign bus.Data      = {hh_q, mm_q, ss_q};
   assign bus.full_flag = full_q;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter (TICK_DIV=4):
// seconds-of-day model plus literal checkpoints.
module tb_time_counter;

   localparam int TD = 4;

   logic Clk = 1'b0;
   logic Reset = 1'b0;

   time_counter_if bus();

   time_counter #(
      .TICK_DIV (TD)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   // Model state: time as seconds since midnight.
   int       m_sod = 0;
   int       m_pre = 0;
   logic [2:0] m_pi = 3'b111;
   logic [2:0] m_pd = 3'b111;
   logic     m_full = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   bit          lit_valid = 1'b0;
   string       lit_tag = "";
   logic [23:0] lit_data = '0;
   logic        lit_full = 1'b0;

   function automatic logic [7:0] to_bcd(input int x);
      logic [3:0] t;
      logic [3:0] u;
      t = 4'(x / 10);
      u = 4'(x % 10);
      return {t, u};
   endfunction

   function automatic logic [23:0] exp_data(input int sod);
      return {to_bcd(sod / 3600),
              to_bcd((sod / 60) % 60),
              to_bcd(sod % 60)};
   endfunction

   function automatic int nxt_sod(
      input int sod, input logic [2:0] ie,
      input logic [2:0] de, input bit tk
   );
      int h, m, s;
      if (|(ie | de)) begin
         h = sod / 3600;
         m = (sod / 60) % 60;
         s = sod % 60;
         s = (s + int'(ie[0]) - int'(de[0]) + 60) % 60;
         m = (m + int'(ie[1]) - int'(de[1]) + 60) % 60;
         h = (h + int'(ie[2]) - int'(de[2]) + 24) % 24;
         return h * 3600 + m * 60 + s;
      end
      if (tk)
         return (sod + 1) % 86400;
      return sod;
   endfunction

   function automatic int nxt_pre(
      input int pre, input logic [2:0] ie,
      input logic [2:0] de, input logic rn
   );
      if (ie[0] | de[0])
         return 0;
      if (!rn)
         return pre;
      return (pre + 1) % TD;
   endfunction

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_sod  <= 0;
         m_pre  <= 0;
         m_pi   <= 3'b111;
         m_pd   <= 3'b111;
         m_full <= 1'b0;
      end else begin
         m_pi  <= bus.cnt_inc;
         m_pd  <= bus.cnt_dec;
         m_sod <= nxt_sod(m_sod,
                          bus.cnt_inc & ~m_pi,
                          bus.cnt_dec & ~m_pd,
                          bus.run && m_pre == TD - 1);
         m_pre <= nxt_pre(m_pre,
                          bus.cnt_inc & ~m_pi,
                          bus.cnt_dec & ~m_pd,
                          bus.run);
         m_full <= bus.run && m_pre == TD - 1
                   && !(|((bus.cnt_inc & ~m_pi)
                        | (bus.cnt_dec & ~m_pd)))
                   && m_sod == 86399;
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         n_cmp++;
         if (bus.Data !== exp_data(m_sod)
             || bus.full_flag !== m_full) begin
            n_bad++;
            $display("FAIL model t=%0t Data=%h full=%b exp %h/%b",
                     $time, bus.Data, bus.full_flag,
                     exp_data(m_sod), m_full);
         end
      end
      if (lit_valid) begin
         n_cmp++;
         if (bus.Data !== lit_data
             || bus.full_flag !== lit_full) begin
            n_bad++;
            $display("FAIL %s Data=%h full=%b exp %h/%b",
                     lit_tag, bus.Data, bus.full_flag,
                     lit_data, lit_full);
         end
      end
   end

   task automatic at_edge(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic lit(
      input string tag, input logic [23:0] d,
      input logic f
   );
      lit_tag   = tag;
      lit_data  = d;
      lit_full  = f;
      lit_valid = 1'b1;
      @(negedge Clk);
      #1;
      lit_valid = 1'b0;
   endtask

   task automatic pulse(
      input logic [2:0] i, input logic [2:0] d
   );
      at_edge(1);
      bus.cnt_inc = i;
      bus.cnt_dec = d;
      at_edge(1);
      bus.cnt_inc = 3'b000;
      bus.cnt_dec = 3'b000;
   endtask

   initial begin
      bus.run     = 1'b0;
      bus.cnt_inc = 3'b000;
      bus.cnt_dec = 3'b000;
      #3;
      Reset  = 1'b1;
      chk_en = 1'b1;
      lit("reset", 24'h000000, 1'b0);

      // free run
      at_edge(1);
      Reset   = 1'b0;
      bus.run = 1'b1;
      at_edge(16);
      lit("free_run", 24'h000004, 1'b0);
      at_edge(1);
      bus.run = 1'b0;

      // set 23:59:58 by adjusts
      pulse(3'b000, 3'b111);
      lit("dec_all", 24'h235903, 1'b0);
      repeat (5) pulse(3'b000, 3'b001);
      lit("set_58", 24'h235958, 1'b0);

      // day rollover
      at_edge(1);
      bus.run = 1'b1;
      at_edge(4);
      lit("at_59", 24'h235959, 1'b0);
      at_edge(3);
      lit("pre_roll", 24'h235959, 1'b0);
      at_edge(1);
      lit("rollover", 24'h000000, 1'b1);
      at_edge(1);
      lit("post_roll", 24'h000000, 1'b0);

      // held decrement wraps once, no borrow
      at_edge(1);
      bus.run     = 1'b0;
      bus.cnt_dec = 3'b111;
      at_edge(1);
      lit("dec_wrap", 24'h235959, 1'b0);
      at_edge(4);
      bus.cnt_dec = 3'b000;
      lit("dec_held", 24'h235959, 1'b0);

      // conflicts
      pulse(3'b010, 3'b010);
      lit("min_conflict", 24'h235959, 1'b0);
      at_edge(1);
      bus.run = 1'b1;
      at_edge(3);
      bus.cnt_inc = 3'b001;
      at_edge(1);
      bus.cnt_inc = 3'b000;
      lit("tick_adj", 24'h235900, 1'b0);
      at_edge(3);
      lit("pre_restart", 24'h235900, 1'b0);
      at_edge(1);
      lit("next_tick", 24'h235901, 1'b0);
      at_edge(1);
      bus.run = 1'b0;

      // request held through reset release
      at_edge(1);
      Reset       = 1'b1;
      bus.cnt_inc = 3'b100;
      at_edge(2);
      Reset = 1'b0;
      at_edge(3);
      bus.cnt_inc = 3'b000;
      lit("hold_rst", 24'h000000, 1'b0);

      // independent fields together
      pulse(3'b011, 3'b100);
      lit("multi", 24'h230101, 1'b0);

      // reset one cycle before the day tick
      pulse(3'b000, 3'b011);
      pulse(3'b000, 3'b011);
      lit("set_59", 24'h235959, 1'b0);
      at_edge(1);
      bus.run = 1'b1;
      at_edge(3);
      Reset = 1'b1;
      lit("rst_pre_tick", 24'h000000, 1'b0);
      at_edge(1);
      Reset = 1'b0;
      at_edge(2);
      lit("after_rst", 24'h000000, 1'b0);
      at_edge(12);
      lit("run_after", 24'h000003, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000: Clk cycles per one-second tick; legal range 2..2^26.
REQ-002 SHALL have port Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port run  input  1  1 = time advances; 0 = time frozen, prescaler held.
REQ-005 SHALL have port cnt_inc  input  3  increment requests, synchronous to Clk: bit0 seconds, bit1 minutes, bit2 hours.
REQ-006 SHALL have port cnt_dec  input  3  decrement requests, same bit mapping as cnt_inc.
REQ-007 SHALL have port full_flag  output  1  one-cycle day-carry pulse, fed to the calendar stage.
REQ-008 SHALL have port Data  output  24  BCD time: [23:16] hours 00-23, [15:8] minutes 00-59, [7:0] seconds 00-59.

Function
REQ-009 SHALL hold a prescaler that counts 0..TICK_DIV-1 while run=1, generating an internal tick in the cycle it equals TICK_DIV-1, then wrapping to 0.
REQ-010 SHALL, on tick, advance seconds by 1; 59->00 carries into minutes; minutes 59->00 carries into hours; hours 23->00.
REQ-011 SHALL keep every BCD digit legal at all times: low digit 0-9, seconds/minutes tens 0-5, hours 00-23.
REQ-012 SHALL register Data; a tick in cycle k is visible on Data after rising edge k.
REQ-013 SHALL assert full_flag for exactly one cycle, coincident with Data first showing 00:00:00 after a tick-driven 23:59:59 rollover.
REQ-014 SHALL detect a rising edge per cnt_inc/cnt_dec bit: bit sampled 1 with its previous registered sample 0; each edge is one adjust event; a held bit produces only one event.
REQ-015 SHALL apply an adjust event to its field only, wrapping within that field without carry or borrow (seconds/minutes 59<->00, hours 23<->00).
REQ-016 SHALL apply the result of an adjust event on the same rising edge at which the edge is detected.
REQ-017 SHALL treat inc and dec edges on the same field in the same cycle as no change.
REQ-018 SHALL allow simultaneous adjust events on different fields; each field is updated independently.
REQ-019 SHALL, in a cycle with any adjust event, discard a coincident tick: no time advance and no full_flag.
REQ-020 SHALL clear the prescaler to 0 on any seconds adjust event (bit0 of cnt_inc or cnt_dec).
REQ-021 SHALL never assert full_flag as a result of an adjust-driven wrap.
REQ-022 SHALL, while run=0, hold the prescaler and time, and still accept adjust events.

Reset
REQ-023 SHALL, while Reset=1, asynchronously force Data=24'h000000, full_flag=0, prescaler=0.
REQ-024 SHALL, while Reset=1, set the previous-sample registers for cnt_inc and cnt_dec to 3'b111, so a request held through reset release causes no adjust.
REQ-025 SHALL abandon any in-progress rollover when Reset asserts mid-operation; no full_flag is produced after release.

Verification (TICK_DIV=4 unless stated)
REQ-026 SHALL cover free run: Reset pulse, run=1 for 16 cycles -> Data steps 000000, 000001 .. 000004, one step every 4 cycles; full_flag stays 0.
REQ-027 SHALL cover day rollover: set to 23:59:58 by adjusts, then run -> Data 235959 then 000000; full_flag high for exactly that one cycle.
REQ-028 SHALL cover adjust wrap: at 00:00:00, cnt_dec=3'b111 held 5 cycles -> Data=235959 after the first edge only; no full_flag; no minute/hour borrow.
REQ-029 SHALL cover conflicts: cnt_inc[1] and cnt_dec[1] rise together -> minutes unchanged; cnt_inc[0] rises in the tick cycle -> seconds +1 only and prescaler restarts at 0.
REQ-030 SHALL cover reset interaction: cnt_inc=3'b100 held through Reset release -> hours stay 00; Reset asserted at 23:59:59 one cycle before the tick -> Data=000000 immediately, no full_flag.
